// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for the parallel conv engine: reads one frame of
// channel-packed pixels from a sync-read image memory, streams them to the
// engine after a start-of-frame pulse, and counts engine outputs until the
// frame completes or times out.
module conv_frame_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_CHANNEL = 3,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int OUT_COUNT  = IMG_WIDTH * IMG_HEIGHT,
    parameter int TIMEOUT    = 2000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             pause,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout_err,
    output logic                             mem_rd_en,
    output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
    input  logic [IN_CHANNEL*DATA_WIDTH-1:0] mem_rd_data,
    output logic                             frame_start,
    output logic [IN_CHANNEL*DATA_WIDTH-1:0] pixel_in,
    output logic                             pixel_valid,
    input  logic                             conv_valid,
    output logic [ADDR_WIDTH:0]              out_count,
    output logic [15:0]                      frame_cycles
);

    localparam int PW = IN_CHANNEL * DATA_WIDTH;
    localparam int CW = ADDR_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [CW-1:0]         OUT_MAX   = CW'(OUT_COUNT);
    localparam logic [TW-1:0]         TO_MAX    = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                  rd_vld_q, rd_vld_d;   // read issued last cycle, data on mem_rd_data now
    logic                  pix_vld_q, pix_vld_d;
    logic [PW-1:0]         pix_q, pix_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  terr_q, terr_d;
    logic                  sof_q, sof_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [15:0]           fcyc_q, fcyc_d;
    logic [TW-1:0]         to_q, to_d;
    logic                  rd_en;
    logic                  cv_hit;

    // Next-state, pixel pipeline and counter logic
    always_comb begin
        rd_en     = (state_q == S_STREAM) && !pause;
        cv_hit    = conv_valid && (state_q inside {S_SOF, S_STREAM, S_DRAIN});

        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rd_vld_d  = rd_en;
        pix_vld_d = rd_vld_q;
        pix_d     = rd_vld_q ? mem_rd_data : pix_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        terr_d    = terr_q;
        sof_d     = 1'b0;
        cnt_d     = cnt_q;
        fcyc_d    = fcyc_q;
        to_d      = to_q;

        // frame_cycles covers SOF through the DONE cycle, saturating
        if (state_q != S_IDLE && fcyc_q != '1)
            fcyc_d = fcyc_q + 16'd1;

        if (cv_hit && cnt_q != OUT_MAX)
            cnt_d = cnt_q + 1'b1;

        // Idle-cycle watchdog: any engine activity restarts it, pause freezes it
        if (cv_hit || pix_vld_q)
            to_d = '0;
        else if ((state_q == S_STREAM || state_q == S_DRAIN) && !pause && to_q != TO_MAX)
            to_d = to_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SOF;
                    sof_d    = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    fcyc_d   = '0;
                    terr_d   = 1'b0;
                    to_d     = '0;
                    rd_ptr_d = '0;
                end
            end
            S_SOF: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (rd_en) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == LAST_ADDR) begin
                        rd_ptr_d = '0;
                        state_d  = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!rd_vld_q && !pix_vld_q && cnt_q == OUT_MAX) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (to_q == TO_MAX) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    terr_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; async reset discards any in-flight pixels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rd_ptr_q  <= '0;
            rd_vld_q  <= 1'b0;
            pix_vld_q <= 1'b0;
            pix_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            terr_q    <= 1'b0;
            sof_q     <= 1'b0;
            cnt_q     <= '0;
            fcyc_q    <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_vld_q  <= rd_vld_d;
            pix_vld_q <= pix_vld_d;
            pix_q     <= pix_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            terr_q    <= terr_d;
            sof_q     <= sof_d;
            cnt_q     <= cnt_d;
            fcyc_q    <= fcyc_d;
            to_q      <= to_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign timeout_err  = terr_q;
    assign mem_rd_en    = rd_en;
    assign mem_rd_addr  = rd_ptr_q;
    assign frame_start  = sof_q;
    assign pixel_in     = pix_q;
    assign pixel_valid  = pix_vld_q;
    assign out_count    = cnt_q;
    assign frame_cycles = fcyc_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer: memory word[a] = a per channel,
// simple engine model answering each pixel with one conv_valid a cycle later.
module tb_conv_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        busy, done, timeout_err, mem_rd_en, frame_start, pixel_valid;
    logic [5:0]  mem_rd_addr;
    logic [23:0] mem_rd_data = '0;
    logic [23:0] pixel_in;
    logic        conv_valid = 1'b0;
    logic [6:0]  out_count;
    logic [15:0] frame_cycles;

    int checks = 0;
    int failures = 0;

    // per-frame observations filled by run_frame
    int n_sof, n_pix, n_done, pix_err, addr_err, overlap, first_pix_off;
    int sof_cyc, done_cyc, last_pix_cyc, gap20, pix_in_pause, sof_terr;

    conv_frame_sequencer #(
        .DATA_WIDTH(8), .IN_CHANNEL(3), .IMG_WIDTH(8), .IMG_HEIGHT(8),
        .ADDR_WIDTH(6), .OUT_COUNT(64), .TIMEOUT(2000)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .frame_start(frame_start), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .conv_valid(conv_valid), .out_count(out_count), .frame_cycles(frame_cycles)
    );

    always #5 clk = ~clk;

    // sync-read image memory model: word[a] = a replicated per channel
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= {3{2'b00, mem_rd_addr}};
    end

    // cv_mode: 0 echo pixels, 1 silent engine, 2 echo pixels plus 6 extra pulses
    // start_mode: 1 = extra start pulses in STREAM and in the DONE cycle
    task automatic run_frame(input int pause_at, input int cv_mode, input int start_mode,
                             input int abort_at, input int post_max, input int max_cyc);
        int reads = 0, pause_left = 0, post = 0, extra = 0;
        bit prev_pv = 0, pdone = 0;
        logic [23:0] exp;
        n_sof = 0; n_pix = 0; n_done = 0; pix_err = 0; addr_err = 0; overlap = 0;
        first_pix_off = -1; sof_cyc = -1; done_cyc = -1; last_pix_cyc = 0; gap20 = -1;
        pix_in_pause = 0; sof_terr = -1;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == 0) || (start_mode == 1 && (cyc == 12 || done === 1'b1));
            if (pause_left > 0) begin pause = 1'b1; pause_left--; end
            else pause = 1'b0;
            if (prev_pv) conv_valid = 1'b1;
            else if (cv_mode == 2 && n_pix == 64 && extra < 6) begin conv_valid = 1'b1; extra++; end
            else conv_valid = 1'b0;
            if (cv_mode == 1) conv_valid = 1'b0;
            @(negedge clk);
            if (frame_start === 1'b1) begin n_sof++; sof_cyc = cyc; sof_terr = int'(timeout_err); end
            if (mem_rd_en === 1'b1) begin
                if (mem_rd_addr !== reads[5:0]) addr_err++;
                reads++;
                if (pause_at > 0 && reads == pause_at && !pdone) begin pause_left = 5; pdone = 1; end
            end
            if (pixel_valid === 1'b1) begin
                exp = {3{n_pix[7:0]}};
                if (pixel_in !== exp) pix_err++;
                if (n_pix == 0) first_pix_off = cyc - sof_cyc;
                if (n_pix == 20) gap20 = cyc - last_pix_cyc - 1;
                if (pause === 1'b1) pix_in_pause++;
                if (frame_start === 1'b1) overlap++;
                last_pix_cyc = cyc;
                n_pix++;
            end
            prev_pv = (pixel_valid === 1'b1);
            if (n_done > 0) post++;
            if (done === 1'b1) begin n_done++; done_cyc = cyc; end
            if (abort_at > 0 && n_pix == abort_at) break;
            if (n_done > 0 && post >= post_max) break;
        end
        start = 1'b0; pause = 1'b0; conv_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if ({busy, done, timeout_err, mem_rd_en, frame_start, pixel_valid} !== 6'b0) begin
            failures++; $display("FAIL reset_flags: got %b expected 000000",
                {busy, done, timeout_err, mem_rd_en, frame_start, pixel_valid}); end
        checks++; if (pixel_in !== 24'h0 || mem_rd_addr !== 6'd0) begin
            failures++; $display("FAIL reset_data: pixel_in=%h addr=%0d expected 0/0", pixel_in, mem_rd_addr); end
        checks++; if (out_count !== 7'd0 || frame_cycles !== 16'd0) begin
            failures++; $display("FAIL reset_counts: out_count=%0d frame_cycles=%0d expected 0/0", out_count, frame_cycles); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_frame(0, 0, 0, 0, 3, 300);
        checks++; if (n_sof != 1) begin failures++; $display("FAIL basic_sof: got %0d expected 1", n_sof); end
        checks++; if (n_pix != 64) begin failures++; $display("FAIL basic_pixels: got %0d expected 64", n_pix); end
        checks++; if (pix_err != 0 || addr_err != 0) begin failures++;
            $display("FAIL basic_order: pix_err=%0d addr_err=%0d expected 0/0", pix_err, addr_err); end
        checks++; if (first_pix_off != 3) begin failures++; $display("FAIL basic_latency: got %0d expected 3", first_pix_off); end
        checks++; if (overlap != 0) begin failures++; $display("FAIL basic_overlap: got %0d expected 0", overlap); end
        checks++; if (n_done != 1) begin failures++; $display("FAIL basic_done: got %0d expected 1", n_done); end
        checks++; if (out_count !== 7'd64) begin failures++; $display("FAIL basic_out_count: got %0d expected 64", out_count); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL basic_terr: got %b expected 0", timeout_err); end
        checks++; if (frame_cycles !== 16'd70) begin failures++; $display("FAIL basic_frame_cycles: got %0d expected 70", frame_cycles); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_pause();
        run_frame(20, 0, 0, 0, 3, 300);
        checks++; if (n_pix != 64 || pix_err != 0) begin failures++;
            $display("FAIL pause_pixels: count=%0d errs=%0d expected 64/0", n_pix, pix_err); end
        checks++; if (pix_in_pause != 2) begin failures++; $display("FAIL pause_inflight: got %0d expected 2", pix_in_pause); end
        checks++; if (gap20 != 5) begin failures++; $display("FAIL pause_gap: got %0d expected 5", gap20); end
        checks++; if (n_done != 1 || out_count !== 7'd64) begin failures++;
            $display("FAIL pause_done: done=%0d out_count=%0d expected 1/64", n_done, out_count); end
    endtask

    task automatic test_timeout();
        run_frame(0, 1, 0, 0, 0, 2500);
        checks++; if (n_pix != 64) begin failures++; $display("FAIL to_pixels: got %0d expected 64", n_pix); end
        checks++; if (n_done != 1 || timeout_err !== 1'b1) begin failures++;
            $display("FAIL to_flag: done=%0d terr=%b expected 1/1", n_done, timeout_err); end
        checks++; if (out_count !== 7'd0) begin failures++; $display("FAIL to_out_count: got %0d expected 0", out_count); end
        checks++; if (done_cyc - last_pix_cyc < 2000 || done_cyc - last_pix_cyc > 2003) begin failures++;
            $display("FAIL to_delay: got %0d expected 2000..2003", done_cyc - last_pix_cyc); end
        // engine pulses while idle must not count; flag stays sticky
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1 conv_valid = 1'b1; end
        @(posedge clk); #1 conv_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_count !== 7'd0 || timeout_err !== 1'b1) begin failures++;
            $display("FAIL to_idle_hold: out_count=%0d terr=%b expected 0/1", out_count, timeout_err); end
        run_frame(0, 0, 0, 0, 3, 300);
        checks++; if (sof_terr != 0 || timeout_err !== 1'b0) begin failures++;
            $display("FAIL to_clear: sof_terr=%0d terr=%b expected 0/0", sof_terr, timeout_err); end
    endtask

    task automatic test_back_to_back();
        run_frame(0, 0, 1, 0, 0, 300);
        checks++; if (n_sof != 1 || n_done != 1 || n_pix != 64) begin failures++;
            $display("FAIL b2b_first: sof=%0d done=%0d pix=%0d expected 1/1/64", n_sof, n_done, n_pix); end
        run_frame(0, 0, 0, 0, 3, 300);
        checks++; if (sof_cyc != 1 || n_sof != 1) begin failures++;
            $display("FAIL b2b_second_sof: cyc=%0d count=%0d expected 1/1", sof_cyc, n_sof); end
        checks++; if (n_pix != 64 || pix_err != 0 || n_done != 1) begin failures++;
            $display("FAIL b2b_second_frame: pix=%0d errs=%0d done=%0d expected 64/0/1", n_pix, pix_err, n_done); end
    endtask

    task automatic test_rst_midframe();
        run_frame(0, 0, 0, 30, 0, 300);
        checks++; if (n_pix != 30) begin failures++; $display("FAIL rst_reach: got %0d expected 30", n_pix); end
        rst = 1'b1;
        #1;
        checks++; if ({busy, done, mem_rd_en, frame_start, pixel_valid} !== 5'b0 || pixel_in !== 24'h0) begin
            failures++; $display("FAIL rst_outputs: flags=%b pixel_in=%h expected 00000/0",
                {busy, done, mem_rd_en, frame_start, pixel_valid}, pixel_in); end
        checks++; if (out_count !== 7'd0 || frame_cycles !== 16'd0 || mem_rd_addr !== 6'd0) begin failures++;
            $display("FAIL rst_counts: out=%0d fc=%0d addr=%0d expected 0/0/0", out_count, frame_cycles, mem_rd_addr); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++;
            $display("FAIL rst_no_done: done=%b busy=%b expected 0/0", done, busy); end
        run_frame(0, 0, 0, 0, 3, 300);
        checks++; if (n_pix != 64 || pix_err != 0 || addr_err != 0 || n_done != 1) begin failures++;
            $display("FAIL rst_fresh: pix=%0d errs=%0d/%0d done=%0d expected 64/0/0/1", n_pix, pix_err, addr_err, n_done); end
    endtask

    task automatic test_saturate();
        run_frame(0, 2, 0, 0, 8, 300);
        checks++; if (out_count !== 7'd64) begin failures++; $display("FAIL sat_out_count: got %0d expected 64", out_count); end
        checks++; if (n_done != 1) begin failures++; $display("FAIL sat_done: got %0d expected 1", n_done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_timeout();
        test_back_to_back();
        test_rst_midframe();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
